// File: rtl/bist_multichain_controller.sv
// bist_multichain_controller: LFSR-driven multi-chain scan BIST with MISR compaction and golden compare
module bist_multichain_controller #(
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_LENGTH = 263,
  parameter int NUM_PATTERNS = 2000,
  parameter int LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'h0001,
  parameter int SIG_WIDTH = 16,
  parameter logic [SIG_WIDTH-1:0] MISR_TAPS = 16'hB400,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bistmode,
  input  logic [NUM_CHAINS-1:0] cut_sdo,
  output logic                  cut_scanmode,
  output logic [NUM_CHAINS-1:0] cut_sdi,
  output logic                  bistdone,
  output logic                  bistpass,
  output logic [SIG_WIDTH-1:0]  signature
);
  localparam int SW = $clog2(CHAIN_LENGTH);
  localparam int PW = $clog2(NUM_PATTERNS + 1);
  typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE} state_e;
  state_e state_q, state_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [SIG_WIDTH-1:0] misr_q, misr_d, misr_step, sig_q, sig_d;
  logic [SW-1:0] shift_cnt_q, shift_cnt_d;
  logic [PW-1:0] pat_cnt_q, pat_cnt_d;
  logic bm_q, armed_q, scan_q, scan_d, done_q, done_d, pass_q, pass_d;
  logic [NUM_CHAINS-1:0] sdi_q, sdi_d;
  logic start, last_shift, abort;
  // armed_q demands a low sample after reset, so bistmode held high through reset cannot start a run
  assign start = bistmode & ~bm_q & armed_q;
  assign last_shift = shift_cnt_q == SW'(CHAIN_LENGTH - 1);
  assign abort = ~bistmode & (state_q inside {SHIFT, CAPTURE, UNLOAD, COMPARE});
  assign lfsr_step = {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
  assign misr_step = {misr_q[SIG_WIDTH-2:0], ^(misr_q & MISR_TAPS)} ^ SIG_WIDTH'(cut_sdo);
  always_comb begin
    state_d = state_q;
    lfsr_d = lfsr_q;
    misr_d = misr_q;
    shift_cnt_d = shift_cnt_q;
    pat_cnt_d = pat_cnt_q;
    pass_d = pass_q;
    sig_d = sig_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        lfsr_d = LFSR_SEED;
        misr_d = '0;
        shift_cnt_d = '0;
        pat_cnt_d = '0;
      end
      SHIFT: begin
        lfsr_d = lfsr_step;
        misr_d = pat_cnt_q != '0 ? misr_step : misr_q;
        shift_cnt_d = last_shift ? '0 : shift_cnt_q + 1'b1;
        state_d = last_shift ? CAPTURE : SHIFT;
      end
      CAPTURE: begin
        pat_cnt_d = pat_cnt_q + 1'b1;
        state_d = pat_cnt_q == PW'(NUM_PATTERNS - 1) ? UNLOAD : SHIFT;
      end
      UNLOAD: begin
        misr_d = misr_step;
        shift_cnt_d = last_shift ? '0 : shift_cnt_q + 1'b1;
        state_d = last_shift ? COMPARE : UNLOAD;
      end
      COMPARE: begin
        sig_d = misr_q;
        pass_d = misr_q == GOLDEN_SIG;
        state_d = DONE;
      end
      DONE: state_d = bistmode ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      pass_d = 1'b0;
      sig_d = sig_q;
    end
    scan_d = state_d inside {SHIFT, UNLOAD};
    sdi_d = state_d == SHIFT ? lfsr_d[NUM_CHAINS-1:0] : '0;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lfsr_q <= LFSR_SEED;
      misr_q <= '0;
      shift_cnt_q <= '0;
      pat_cnt_q <= '0;
      bm_q <= 1'b0;
      armed_q <= 1'b0;
      scan_q <= 1'b0;
      sdi_q <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      sig_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      misr_q <= misr_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q <= pat_cnt_d;
      bm_q <= bistmode;
      armed_q <= armed_q | ~bistmode;
      scan_q <= scan_d;
      sdi_q <= sdi_d;
      done_q <= done_d;
      pass_q <= pass_d;
      sig_q <= sig_d;
    end
  end
  assign cut_scanmode = scan_q;
  assign cut_sdi = sdi_q;
  assign bistdone = done_q;
  assign bistpass = pass_q;
  assign signature = sig_q;
endmodule

// File: tb/tb_bist_multichain_controller.sv
// tb_bist_multichain_controller: random-abort BIST runs against a run-level reference model of the controller and CUT
module tb_bist_multichain_controller;
  localparam int NC = 4, L = 8, NP = 3, LAT = NP * (L + 1) + L + 1;
  localparam int FC = 2, FB = 5;
  function automatic logic [31:0] cut_upd(input logic [31:0] c, input logic sm, input logic [3:0] sdi,
                                          input int nc, input int ln, input logic flt, input int fc, input int fb);
    logic [31:0] n;
    n = c;
    for (int i = 0; i < nc; i++)
      for (int j = 0; j < ln; j++)
        n[i*ln+j] = sm ? (j == 0 ? sdi[i] : c[i*ln+j-1])
                       : c[i*ln+j] ^ (c[((i+1)%nc)*ln+(j+1)%ln] & c[i*ln+(j+2)%ln]);
    if (flt) n[fc*ln+fb] = 1'b0;
    return n;
  endfunction
  function automatic logic [15:0] ref_sig(input int nc, input int ln, input int np, input logic flt, input int fc, input int fb);
    logic [31:0] c;
    logic [15:0] l, s;
    logic [3:0] sdo, sdi;
    c = '0;
    l = 16'h0001;
    s = '0;
    for (int p = 0; p <= np; p++) begin
      for (int t = 0; t < ln; t++) begin
        sdo = '0;
        for (int i = 0; i < nc; i++) sdo[i] = c[i*ln+ln-1];
        if (p > 0) s = {s[14:0], ^(s & 16'hB400)} ^ {12'h000, sdo};
        sdi = p < np ? l[3:0] : 4'h0;
        c = cut_upd(c, 1'b1, sdi, nc, ln, flt, fc, fb);
        if (p < np) l = {l[14:0], ^(l & 16'hB400)};
      end
      if (p < np) c = cut_upd(c, 1'b0, 4'h0, nc, ln, flt, fc, fb);
    end
    return s;
  endfunction
  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] l;
    l = 16'h0001;
    for (int i = 0; i < n; i++) l = {l[14:0], ^(l & 16'hB400)};
    return l;
  endfunction
  localparam logic [15:0] GOLD = ref_sig(NC, L, NP, 1'b0, 0, 0);

  logic clk = 1'b0, rst = 1'b1, bistmode = 1'b0, bm2 = 1'b0, flt = 1'b0;
  logic [NC-1:0] sdo, sdi;
  logic scan, done, pass;
  logic [15:0] sig;
  logic [0:0] sdo2, sdi2;
  logic scan2, done2, pass2;
  logic [15:0] sig2;
  logic [31:0] cut, cut2;
  int n_chk = 0, n_fail = 0, n_scan_hi = 0;
  bit m_run = 0, m_done = 0, m_prev = 1;
  int m_k = 0;
  logic e_pass = 1'b0;
  logic [15:0] e_sig = '0;

  always #5 clk = ~clk;

  bist_multichain_controller #(.NUM_CHAINS(NC), .CHAIN_LENGTH(L), .NUM_PATTERNS(NP), .GOLDEN_SIG(GOLD)) dut (
    .clk(clk), .rst(rst), .bistmode(bistmode), .cut_sdo(sdo), .cut_scanmode(scan), .cut_sdi(sdi),
    .bistdone(done), .bistpass(pass), .signature(sig));
  bist_multichain_controller #(.NUM_CHAINS(1), .CHAIN_LENGTH(2), .NUM_PATTERNS(1)) dut2 (
    .clk(clk), .rst(rst), .bistmode(bm2), .cut_sdo(sdo2), .cut_scanmode(scan2), .cut_sdi(sdi2),
    .bistdone(done2), .bistpass(pass2), .signature(sig2));

  // circuits under test: plain shift chains with a nonlinear capture function and an optional stuck-at-0 flop
  always @(posedge clk) cut <= cut_upd(cut, scan, sdi, NC, L, flt, FC, FB);
  always @(posedge clk) cut2 <= cut_upd(cut2, scan2, {3'b000, sdi2}, 1, 2, 1'b0, 0, 0);
  assign sdo = {cut[31], cut[23], cut[15], cut[7]};
  assign sdo2 = cut2[1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // run-level model: m_k is the cycle index since IDLE was left
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_done = 0; m_k = 0; m_prev = 1; e_pass = 1'b0; e_sig = '0;
    end else begin
      if (m_run) begin
        if (!bistmode) begin
          m_run = 0; e_pass = 1'b0;
        end else if (m_k == LAT - 1) begin
          m_run = 0; m_done = 1;
          e_sig = ref_sig(NC, L, NP, flt, FC, FB);
          e_pass = e_sig == GOLD;
        end else m_k++;
      end else if (m_done) begin
        if (!bistmode) m_done = 0;
      end else if (bistmode && !m_prev) begin
        m_run = 1; m_k = 0;
      end
      m_prev = bistmode;
    end
  end

  always @(negedge clk) begin
    bit sh, es;
    logic [15:0] lv;
    if (rst) begin
      sh = m_run && m_k < NP * (L + 1) && (m_k % (L + 1)) != L;
      es = m_run && (m_k < NP * (L + 1) ? (m_k % (L + 1)) != L : m_k < NP * (L + 1) + L);
      lv = sh ? lfsr_at((m_k / (L + 1)) * L + m_k % (L + 1)) : 16'h0000;
      chk("scanmode", 32'(scan), 32'(es));
      chk("sdi", 32'(sdi), 32'(lv[3:0]));
      chk("done", 32'(done), 32'(m_done));
      chk("pass", 32'(pass), 32'(e_pass));
      chk("signature", 32'(sig), 32'(e_sig));
      if (scan) n_scan_hi++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_main(output int lat, output int lows);
    bistmode = 1'b1;
    lat = 0;
    lows = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (!scan && lat < LAT) lows++;
    end
    lat = lat - 1;
  endtask

  initial begin
    int lat, lows, s0;
    cut = $urandom;
    cut2 = $urandom;
    #1 rst = 1'b0;
    cyc(3);
    chk("rst_scan", 32'(scan), 0);
    chk("rst_sdi", 32'(sdi), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_sig", 32'(sig), 0);
    rst = 1'b1;
    cyc(2);
    run_main(lat, lows);
    chk("latency", lat, 36);
    chk("capture_cycles", lows, 3);
    chk("golden_sig", 32'(sig), 32'(GOLD));
    chk("golden_pass", 32'(pass), 1);
    s0 = n_scan_hi;
    cyc(100);
    chk("held_done", 32'(done), 1);
    chk("no_restart", n_scan_hi - s0, 0);
    bistmode = 1'b0;
    cyc(2);
    run_main(lat, lows);
    chk("rerun_sig", 32'(sig), 32'(GOLD));
    bistmode = 1'b0;
    cyc(2);
    bistmode = 1'b1;
    cyc(13);
    bistmode = 1'b0;
    cyc(1);
    chk("abort_scan", 32'(scan), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_pass", 32'(pass), 0);
    chk("abort_sig_kept", 32'(sig), 32'(GOLD));
    cyc(1);
    run_main(lat, lows);
    chk("after_abort_sig", 32'(sig), 32'(GOLD));
    for (int r = 0; r < 4; r++) begin
      bistmode = 1'b0;
      cyc(2);
      bistmode = 1'b1;
      cyc($urandom_range(1, LAT));
    end
    bistmode = 1'b0;
    cyc(2);
    flt = 1'b1;
    run_main(lat, lows);
    chk("fault_pass", 32'(pass), 0);
    chk("fault_latency", lat, 36);
    bistmode = 1'b0;
    cyc(2);
    flt = 1'b0;
    bistmode = 1'b1;
    cyc(1 + NP * (L + 1) + 3);
    #2 rst = 1'b0;
    #1;
    chk("async_scan", 32'(scan), 0);
    chk("async_sdi", 32'(sdi), 0);
    chk("async_done", 32'(done), 0);
    chk("async_pass", 32'(pass), 0);
    chk("async_sig", 32'(sig), 0);
    @(negedge clk);
    rst = 1'b1;
    s0 = n_scan_hi;
    cyc(20);
    chk("no_start_high", n_scan_hi - s0, 0);
    chk("no_start_done", 32'(done), 0);
    bistmode = 1'b0;
    cyc(1);
    run_main(lat, lows);
    chk("post_rst_sig", 32'(sig), 32'(GOLD));
    bistmode = 1'b0;
    cyc(2);
    bm2 = 1'b1;
    lat = 0;
    while (!done2 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("small_latency", lat - 1, 6);
    chk("small_sig", 32'(sig2), 32'h0002);
    chk("small_sig_model", 32'(sig2), 32'(ref_sig(1, 2, 1, 1'b0, 0, 0)));
    chk("small_pass", 32'(pass2), 0);
    bm2 = 1'b0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/bist_multichain_controller.md
BIST_MULTICHAIN_CONTROLLER -- requirements
Module: bist_multichain_controller

Interface
REQ-001 SHALL have parameter NUM_CHAINS, 4, number of parallel scan chains (1..LFSR_WIDTH, and <= SIG_WIDTH).
REQ-002 SHALL have parameter CHAIN_LENGTH, 263, flops per chain (>= 2).
REQ-003 SHALL have parameter NUM_PATTERNS, 2000, pseudo-random patterns applied per run (>= 1).
REQ-004 SHALL have parameter LFSR_WIDTH, 16, pattern LFSR width.
REQ-005 SHALL have parameter LFSR_TAPS, 16'hB400, feedback tap mask (bit i set = tap at bit i).
REQ-006 SHALL have parameter LFSR_SEED, 16'h0001, LFSR load value at run start (nonzero).
REQ-007 SHALL have parameter SIG_WIDTH, 16, MISR width.
REQ-008 SHALL have parameter MISR_TAPS, 16'hB400, MISR feedback tap mask.
REQ-009 SHALL have parameter GOLDEN_SIG, 16'h0000, expected final signature.
REQ-010 clk  input  1  sole clock, rising edge.
REQ-011 rst  input  1  reset, asynchronous, active-low.
REQ-012 bistmode  input  1  run request; rising edge starts a run, low aborts or acknowledges done.
REQ-013 cut_sdo  input  NUM_CHAINS  scan-out bit of each chain.
REQ-014 cut_scanmode  output  1  1 = CUT shifts, 0 = CUT captures.
REQ-015 cut_sdi  output  NUM_CHAINS  scan-in bit per chain; cut_sdi[i] = LFSR bit i.
REQ-016 bistdone  output  1  run complete; held until bistmode low.
REQ-017 bistpass  output  1  valid when bistdone=1; 1 = signature == GOLDEN_SIG.
REQ-018 signature  output  SIG_WIDTH  final MISR value, registered at COMPARE.

Function
REQ-019 States SHALL be IDLE, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE; all outputs registered.
REQ-020 IDLE: bistmode sampled high with previous sample low -> SHIFT next cycle; LFSR <= LFSR_SEED, MISR <= 0, shift_cnt <= 0, pat_cnt <= 0.
REQ-021 SHIFT: cut_scanmode=1 for exactly CHAIN_LENGTH cycles; LFSR advances one step per cycle; last cycle -> CAPTURE.
REQ-022 CAPTURE: exactly 1 cycle, cut_scanmode=0, LFSR and MISR hold; pat_cnt += 1; pat_cnt==NUM_PATTERNS -> UNLOAD, else -> SHIFT.
REQ-023 UNLOAD: cut_scanmode=1 for CHAIN_LENGTH cycles, LFSR holds, cut_sdi=0; -> COMPARE.
REQ-024 MISR SHALL compact cut_sdo on every SHIFT cycle with pat_cnt>=1 and every UNLOAD cycle; never during the first load, CAPTURE or COMPARE (total NUM_PATTERNS*CHAIN_LENGTH compactions).
REQ-025 MISR step: sig <= {sig[SIG_WIDTH-2:0], ^(sig & MISR_TAPS)} XOR zero-extended cut_sdo.
REQ-026 LFSR step: lfsr <= {lfsr[LFSR_WIDTH-2:0], ^(lfsr & LFSR_TAPS)}.
REQ-027 COMPARE: 1 cycle; signature <= MISR; bistpass <= (MISR == GOLDEN_SIG); -> DONE.
REQ-028 DONE: bistdone=1, cut_scanmode=0; bistmode low -> IDLE with bistdone<=0, bistpass and signature retained.
REQ-029 Run latency: bistdone rises NUM_PATTERNS*(CHAIN_LENGTH+1)+CHAIN_LENGTH+1 cycles after the cycle IDLE is left.
REQ-030 bistmode low in SHIFT/CAPTURE/UNLOAD/COMPARE SHALL abort to IDLE next cycle: cut_scanmode=0, bistdone=0, bistpass=0; signature unchanged.
REQ-031 A new rising edge of bistmode in IDLE SHALL start a fresh run with full reseed; results are deterministic run to run.
REQ-032 bistmode held high through DONE SHALL NOT restart a run.
REQ-033 shift_cnt width $clog2(CHAIN_LENGTH), pat_cnt width $clog2(NUM_PATTERNS+1); no wrap within a run.

Reset
REQ-034 rst low SHALL asynchronously force IDLE, cut_scanmode=0, cut_sdi=0, bistdone=0, bistpass=0, signature=0, LFSR=LFSR_SEED, MISR=0, counters=0, edge-detect register=0.
REQ-035 bistmode high at rst release SHALL NOT start a run; a low-to-high transition is required.

Verification
REQ-036 NUM_CHAINS=4, CHAIN_LENGTH=8, NUM_PATTERNS=3, CUT = 4 shift registers: bistmode rise -> bistdone high exactly 36 cycles after IDLE exit; cut_scanmode low exactly on the 3 CAPTURE cycles.
REQ-037 Same setup, GOLDEN_SIG set to the reference-model signature -> bistpass=1, signature==GOLDEN_SIG; one CUT flop stuck-at-0 -> bistpass=0.
REQ-038 bistmode dropped on cycle 12 of the run -> IDLE next cycle, cut_scanmode=0, bistdone=0; re-raise -> identical signature to an uninterrupted run.
REQ-039 rst asserted mid-UNLOAD -> all outputs at reset values immediately without a clock edge; bistmode held high after release -> no run until low-then-high.
REQ-040 bistmode held high 100 cycles after bistdone -> bistdone stays 1, no second run; drop then raise -> second run yields identical signature.
REQ-041 NUM_CHAINS=1, CHAIN_LENGTH=2, NUM_PATTERNS=1 -> bistdone at cycle 6; exactly 2 MISR compactions.
